// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter and its per-source result FIFOs.
package cdb_arbiter_pkg;

    localparam int RBID      = 4;
    localparam int RLEN      = 32;
    localparam int CDB_DEPTH = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [RBID-1:0] NULL_IDX = '0;
    localparam logic [RLEN-1:0] NULL_VAL = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    typedef struct packed {
        logic [RBID-1:0] idx;
        logic [RLEN-1:0] val;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Result buffer for one execution unit: push when not full, pop on grant, flush on misprediction.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = CDB_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic       i_push,
    input  cdb_entry_t i_push_data,
    input  logic       i_pop,
    output cdb_entry_t o_head_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    cdb_entry_t       r_mem [FIFO_DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_head_data = r_mem[r_head];

    // Fullness is judged on the pre-edge count, so a push into a full buffer is lost even if it pops now.
    assign w_push = i_en && !i_flush && i_push && !o_full;
    assign w_pop  = i_en && !i_flush && i_pop  && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB results onto one registered broadcast bus, alternating grants under contention.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = CDB_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            jp_wrong,
    input  logic            val_flag_ALU,
    input  logic [RBID-1:0] val_idx_ALU,
    input  logic [RLEN-1:0] val_ALU,
    input  logic            val_flag_LSB,
    input  logic [RBID-1:0] val_idx_LSB,
    input  logic [RLEN-1:0] val_LSB,
    output logic            ALU_full,
    output logic            LSB_full,
    output logic            cdb_flag,
    output logic [RBID-1:0] cdb_idx,
    output logic [RLEN-1:0] cdb_val,
    output logic            cdb_src
);

    cdb_entry_t w_alu_head;
    cdb_entry_t w_lsb_head;
    cdb_entry_t w_grant_entry;
    logic       w_alu_empty;
    logic       w_lsb_empty;
    logic       w_grant_vld;
    src_e       w_grant_src;

    src_e            r_last_grant;
    logic            r_cdb_flag;
    logic [RBID-1:0] r_cdb_idx;
    logic [RLEN-1:0] r_cdb_val;
    logic            r_cdb_src;

    cdb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_en        (rdy),
        .i_flush     (jp_wrong),
        .i_push      (val_flag_ALU),
        .i_push_data ({val_idx_ALU, val_ALU}),
        .i_pop       (w_grant_vld && (w_grant_src == SRC_ALU)),
        .o_head_data (w_alu_head),
        .o_full      (ALU_full),
        .o_empty     (w_alu_empty)
    );

    cdb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_en        (rdy),
        .i_flush     (jp_wrong),
        .i_push      (val_flag_LSB),
        .i_push_data ({val_idx_LSB, val_LSB}),
        .i_pop       (w_grant_vld && (w_grant_src == SRC_LSB)),
        .o_head_data (w_lsb_head),
        .o_full      (LSB_full),
        .o_empty     (w_lsb_empty)
    );

    // Under contention the source that did not win last time goes first.
    always_comb begin
        w_grant_vld = FALSE;
        w_grant_src = SRC_ALU;
        if (!w_alu_empty && !w_lsb_empty) begin
            w_grant_vld = TRUE;
            w_grant_src = (r_last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (!w_alu_empty) begin
            w_grant_vld = TRUE;
            w_grant_src = SRC_ALU;
        end else if (!w_lsb_empty) begin
            w_grant_vld = TRUE;
            w_grant_src = SRC_LSB;
        end
    end

    assign w_grant_entry = (w_grant_src == SRC_LSB) ? w_lsb_head : w_alu_head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cdb_flag   <= FALSE;
            r_cdb_idx    <= NULL_IDX;
            r_cdb_val    <= NULL_VAL;
            r_cdb_src    <= SRC_ALU;
            r_last_grant <= SRC_LSB;
        end else if (jp_wrong) begin
            r_cdb_flag   <= FALSE;
            r_last_grant <= SRC_LSB;
        end else if (rdy) begin
            if (w_grant_vld) begin
                r_cdb_flag   <= TRUE;
                r_cdb_idx    <= w_grant_entry.idx;
                r_cdb_val    <= w_grant_entry.val;
                r_cdb_src    <= w_grant_src;
                r_last_grant <= w_grant_src;
            end else begin
                r_cdb_flag   <= FALSE;
            end
        end
    end

    assign cdb_flag = r_cdb_flag;
    assign cdb_idx  = r_cdb_idx;
    assign cdb_val  = r_cdb_val;
    assign cdb_src  = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue-based reference model checked on every falling edge.
module tb_cdb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        jp_wrong = 1'b0;
    logic        vfa = 1'b0;
    logic [3:0]  via = '0;
    logic [31:0] va  = '0;
    logic        vfl = 1'b0;
    logic [3:0]  vil = '0;
    logic [31:0] vl  = '0;

    logic        ALU_full, LSB_full, cdb_flag, cdb_src;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;

    int checks = 0;
    int passes = 0;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .jp_wrong     (jp_wrong),
        .val_flag_ALU (vfa),
        .val_idx_ALU  (via),
        .val_ALU      (va),
        .val_flag_LSB (vfl),
        .val_idx_LSB  (vil),
        .val_LSB      (vl),
        .ALU_full     (ALU_full),
        .LSB_full     (LSB_full),
        .cdb_flag     (cdb_flag),
        .cdb_idx      (cdb_idx),
        .cdb_val      (cdb_val),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: two plain queues and a "who won last" bit.
    logic [35:0] mq_alu[$];
    logic [35:0] mq_lsb[$];
    logic        m_valid = 1'b0;
    logic        m_flag;
    logic [3:0]  m_idx;
    logic [31:0] m_val;
    logic        m_src;
    logic        m_last;

    always @(posedge clk) begin
        int na, nl;
        logic [35:0] e;
        na = mq_alu.size();
        nl = mq_lsb.size();
        if (!rst) begin
            mq_alu.delete(); mq_lsb.delete();
            m_flag = 0; m_idx = 0; m_val = 0; m_src = 0; m_last = 1; m_valid = 1;
        end else if (jp_wrong) begin
            mq_alu.delete(); mq_lsb.delete();
            m_flag = 0; m_last = 1;
        end else if (rdy) begin
            if (na > 0 && (nl == 0 || m_last == 1'b1)) begin
                e = mq_alu.pop_front();
                m_flag = 1; m_idx = e[35:32]; m_val = e[31:0]; m_src = 0; m_last = 0;
            end else if (nl > 0) begin
                e = mq_lsb.pop_front();
                m_flag = 1; m_idx = e[35:32]; m_val = e[31:0]; m_src = 1; m_last = 1;
            end else begin
                m_flag = 0;
            end
            if (vfa && na < DEPTH) mq_alu.push_back({via, va});
            if (vfl && nl < DEPTH) mq_lsb.push_back({vil, vl});
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_flag", 32'(cdb_flag), 32'(m_flag));
            chk("cmp_alu_full", 32'(ALU_full), 32'(mq_alu.size() == DEPTH));
            chk("cmp_lsb_full", 32'(LSB_full), 32'(mq_lsb.size() == DEPTH));
            if (m_flag) begin
                chk("cmp_idx", 32'(cdb_idx), 32'(m_idx));
                chk("cmp_val", cdb_val, m_val);
                chk("cmp_src", 32'(cdb_src), 32'(m_src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_a(input logic f, input int i, input logic [31:0] v);
        vfa = f; via = i[3:0]; va = v;
    endtask

    task automatic push_l(input logic f, input int i, input logic [31:0] v);
        vfl = f; vil = i[3:0]; vl = v;
    endtask

    task automatic idle();
        vfa = 1'b0; vfl = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; jp_wrong = 1'b0; idle();
        tick();
        rst = 1'b1;
    endtask

    task automatic bus(input string name, input logic f, input int i, input logic s);
        chk({name, "_flag"}, 32'(cdb_flag), 32'(f));
        if (f) begin
            chk({name, "_idx"}, 32'(cdb_idx), 32'(i));
            chk({name, "_src"}, 32'(cdb_src), 32'(s));
        end
    endtask

    int ga_cnt, gl_cnt;
    logic seen_a8, seen_l7;

    task automatic count_bc();
        if (cdb_flag) begin
            if (cdb_src == 1'b0) begin
                ga_cnt++;
                if (cdb_idx == 4'd8) seen_a8 = 1'b1;
            end else begin
                gl_cnt++;
                if (cdb_idx == 4'd7) seen_l7 = 1'b1;
            end
        end
    endtask

    int exp_i[4] = '{1, 5, 2, 6};
    logic exp_s[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset state and single-result latency
        tick(); tick();
        chk("rst_flag", 32'(cdb_flag), 0);
        chk("rst_idx", 32'(cdb_idx), 0);
        chk("rst_val", cdb_val, 0);
        chk("rst_src", 32'(cdb_src), 0);
        chk("rst_alu_full", 32'(ALU_full), 0);
        chk("rst_lsb_full", 32'(LSB_full), 0);
        rst = 1'b1;
        push_a(1, 3, 32'h10);
        tick();
        idle();
        chk("lat_e1_flag", 32'(cdb_flag), 0);
        tick();
        bus("lat_e2", 1, 3, 0);
        chk("lat_e2_val", cdb_val, 32'h10);
        tick();
        chk("lat_e3_flag", 32'(cdb_flag), 0);

        // Round-robin under continuous contention
        do_reset();
        push_a(1, 1, 32'h100); push_l(1, 5, 32'h500);
        tick();
        push_a(1, 2, 32'h200); push_l(1, 6, 32'h600);
        tick();
        idle();
        bus("rr0", 1, exp_i[0], exp_s[0]);
        for (int k = 1; k < 4; k++) begin
            tick();
            bus("rr", 1, exp_i[k], exp_s[k]);
        end
        tick();
        chk("rr_done_flag", 32'(cdb_flag), 0);

        // Fill both buffers while the arbiter alternates; overflow pushes are lost
        do_reset();
        ga_cnt = 0; gl_cnt = 0; seen_a8 = 1'b0; seen_l7 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            push_a(1, e, 32'hA000 + e);
            push_l(e <= 7, e, 32'hB000 + e);
            tick();
            count_bc();
            if (e == 6) chk("lsb_full_e6", 32'(LSB_full), 1);
            if (e == 7) begin
                chk("alu_full_e7", 32'(ALU_full), 1);
                chk("lsb_full_e7", 32'(LSB_full), 0);
            end
        end
        idle();
        for (int k = 0; k < 20; k++) begin
            tick();
            count_bc();
        end
        chk("alu_bcast_cnt", 32'(ga_cnt), 7);
        chk("lsb_bcast_cnt", 32'(gl_cnt), 6);
        chk("alu_drop_seen", 32'(seen_a8), 0);
        chk("lsb_drop_seen", 32'(seen_l7), 0);

        // Misprediction flush with entries buffered, a same-edge push, and rdy low
        do_reset();
        push_a(1, 1, 32'h11); push_l(1, 5, 32'h55);
        tick();
        push_a(1, 2, 32'h22); push_l(1, 6, 32'h66);
        tick();
        bus("pre_flush", 1, 1, 0);
        jp_wrong = 1'b1; rdy = 1'b0;
        push_a(1, 3, 32'h33); push_l(1, 7, 32'h77);
        tick();
        jp_wrong = 1'b0; rdy = 1'b1; idle();
        chk("flush_flag", 32'(cdb_flag), 0);
        chk("flush_alu_full", 32'(ALU_full), 0);
        chk("flush_lsb_full", 32'(LSB_full), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_flush_flag", 32'(cdb_flag), 0);
        end

        // Freeze with a live broadcast on the bus
        do_reset();
        push_a(1, 7, 32'h77); push_l(1, 9, 32'h99);
        tick();
        push_a(1, 10, 32'hAA); push_l(0, 0, 0);
        tick();
        bus("pre_hold", 1, 7, 0);
        rdy = 1'b0;
        push_a(1, 12, 32'hCC); push_l(1, 13, 32'hDD);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus("hold", 1, 7, 0);
            chk("hold_val", cdb_val, 32'h77);
        end
        rdy = 1'b1; idle();
        tick();
        bus("resume0", 1, 9, 1);
        chk("resume0_val", cdb_val, 32'h99);
        tick();
        bus("resume1", 1, 10, 0);
        tick();
        chk("resume_done_flag", 32'(cdb_flag), 0);

        // Reset mid-stream, then first contention goes to ALU
        do_reset();
        push_a(1, 1, 32'h1); push_l(1, 5, 32'h5);
        tick();
        push_a(1, 2, 32'h2); push_l(1, 6, 32'h6);
        tick();
        rst = 1'b0;
        push_a(1, 3, 32'h3); push_l(1, 7, 32'h7);
        tick();
        rst = 1'b1;
        chk("mid_rst_flag", 32'(cdb_flag), 0);
        chk("mid_rst_idx", 32'(cdb_idx), 0);
        chk("mid_rst_val", cdb_val, 0);
        chk("mid_rst_src", 32'(cdb_src), 0);
        chk("mid_rst_alu_full", 32'(ALU_full), 0);
        chk("mid_rst_lsb_full", 32'(LSB_full), 0);
        push_a(1, 4, 32'h4); push_l(1, 8, 32'h8);
        tick();
        idle();
        tick();
        bus("post_rst0", 1, 4, 0);
        tick();
        bus("post_rst1", 1, 8, 1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
